// File: rtl/form_error_checker.sv
// Form-error checker for the fixed-form tail of a CAN frame: CRC delimiter,
// ACK delimiter and the End-Of-Frame field, with a latched error and a saturating counter.
module form_error_checker #(
  parameter int EOF_LEN      = 7,
  parameter int CNT_W        = 8,
  parameter int LAST_EOF_TOL = 1
) (
  input  logic             SP,
  input  logic             reset,
  input  logic             RX,
  input  logic             F_CRC_D,
  input  logic             F_ACK_D,
  input  logic             err_clr,
  output logic             FORM_Error,
  output logic [1:0]       err_field,
  output logic [3:0]       eof_pos,
  output logic             eof_active,
  output logic             eof_done,
  output logic             overload_req,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EOF  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLD_NONE = 2'b00,
    FLD_CRC  = 2'b01,
    FLD_ACK  = 2'b10,
    FLD_EOF  = 2'b11
  } field_e;

  localparam logic [3:0]       LAST_POS = 4'(EOF_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  field_e           field_q, field_d;
  logic [3:0]       pos_q, pos_d;
  logic             done_q, done_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_err;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    ovl_d     = 1'b0;
    enter_err = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The CRC delimiter check wins when both field flags are set.
        if (F_CRC_D) begin
          if (!RX) begin
            enter_err = 1'b1;
            field_d   = FLD_CRC;
          end
        end else if (F_ACK_D) begin
          if (RX) begin
            state_d = S_EOF;
            pos_d   = 4'd0;
          end else begin
            enter_err = 1'b1;
            field_d   = FLD_ACK;
          end
        end
      end

      S_EOF: begin
        if (pos_q == LAST_POS) begin
          if (RX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            pos_d   = 4'd0;
          end else if (LAST_EOF_TOL != 0) begin
            // A receiver treats a dominant last EOF bit as an overload frame start.
            ovl_d   = 1'b1;
            state_d = S_IDLE;
            pos_d   = 4'd0;
          end else begin
            enter_err = 1'b1;
            field_d   = FLD_EOF;
          end
        end else if (RX) begin
          pos_d = pos_q + 4'd1;
        end else begin
          enter_err = 1'b1;
          field_d   = FLD_EOF;
        end
      end

      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          field_d = FLD_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        field_d = FLD_NONE;
        pos_d   = 4'd0;
      end
    endcase

    if (enter_err) begin
      state_d = S_ERR;
      pos_d   = 4'd0;
    end

    cnt_d = (enter_err && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge SP) begin
    if (reset) begin
      state_q <= S_IDLE;
      field_q <= FLD_NONE;
      pos_q   <= 4'd0;
      done_q  <= 1'b0;
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign FORM_Error   = (state_q == S_ERR);
  assign eof_active   = (state_q == S_EOF);
  assign err_field    = field_q;
  assign eof_pos      = pos_q;
  assign eof_done     = done_q;
  assign overload_req = ovl_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_form_error_checker.sv
// Bench for form_error_checker: four parameter sets share one stimulus stream;
// a directed vector table, two corner sequences and random traffic against a rule model.
module tb_form_error_checker;

  localparam int NCFG = 4;
  localparam int CFG_LEN [NCFG] = '{7, 7, 2, 15};
  localparam int CFG_CW  [NCFG] = '{8, 8, 2, 4};
  localparam int CFG_TOL [NCFG] = '{1, 0, 1, 0};

  logic SP = 1'b0;
  logic reset, RX, F_CRC_D, F_ACK_D, err_clr;

  logic       fe   [NCFG];
  logic [1:0] fld  [NCFG];
  logic [3:0] pos  [NCFG];
  logic       act  [NCFG];
  logic       done [NCFG];
  logic       ovl  [NCFG];
  logic [7:0] cnt  [NCFG];

  always #5 SP = ~SP;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int LEN = CFG_LEN[g];
    localparam int CW  = CFG_CW[g];
    localparam int TOL = CFG_TOL[g];
    logic [CW-1:0] c;
    form_error_checker #(.EOF_LEN(LEN), .CNT_W(CW), .LAST_EOF_TOL(TOL)) u_dut (
      .SP(SP), .reset(reset), .RX(RX), .F_CRC_D(F_CRC_D), .F_ACK_D(F_ACK_D),
      .err_clr(err_clr), .FORM_Error(fe[g]), .err_field(fld[g]), .eof_pos(pos[g]),
      .eof_active(act[g]), .eof_done(done[g]), .overload_req(ovl[g]), .err_count(c)
    );
    assign cnt[g] = 8'(c);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: one flag per situation, EOF progress as a plain count of recessive bits seen.
  bit m_err [NCFG], m_in_eof [NCFG], m_done [NCFG], m_ovl [NCFG];
  int m_field [NCFG], m_seen [NCFG], m_cnt [NCFG];

  task automatic model_fail(input int i, input int f);
    m_err[i]    = 1'b1;
    m_field[i]  = f;
    m_in_eof[i] = 1'b0;
    m_seen[i]   = 0;
    if (m_cnt[i] < (1 << CFG_CW[i]) - 1) m_cnt[i]++;
  endtask

  task automatic model_update(input bit r, input bit rx, input bit crc, input bit ack, input bit clr);
    for (int i = 0; i < NCFG; i++) begin
      m_done[i] = 1'b0;
      m_ovl[i]  = 1'b0;
      if (r) begin
        m_err[i] = 1'b0; m_in_eof[i] = 1'b0; m_field[i] = 0; m_seen[i] = 0; m_cnt[i] = 0;
      end else if (m_err[i]) begin
        if (clr) begin
          m_err[i]   = 1'b0;
          m_field[i] = 0;
        end
      end else if (m_in_eof[i]) begin
        if (m_seen[i] == CFG_LEN[i] - 1) begin
          if (rx) begin
            m_done[i] = 1'b1; m_in_eof[i] = 1'b0; m_seen[i] = 0;
          end else if (CFG_TOL[i] == 1) begin
            m_ovl[i] = 1'b1; m_in_eof[i] = 1'b0; m_seen[i] = 0;
          end else begin
            model_fail(i, 3);
          end
        end else if (rx) begin
          m_seen[i]++;
        end else begin
          model_fail(i, 3);
        end
      end else if (crc) begin
        if (!rx) model_fail(i, 1);
      end else if (ack) begin
        if (rx) begin
          m_in_eof[i] = 1'b1;
          m_seen[i]   = 0;
        end else begin
          model_fail(i, 2);
        end
      end
    end
  endtask

  function automatic logic [17:0] dut_word(input int i);
    return {fe[i], fld[i], pos[i], act[i], done[i], ovl[i], cnt[i]};
  endfunction

  function automatic logic [17:0] model_word(input int i);
    return {m_err[i], 2'(m_field[i]), 4'(m_seen[i]), m_in_eof[i], m_done[i], m_ovl[i], 8'(m_cnt[i])};
  endfunction

  // One sampled bus bit: drive mid-period, let the edge act, compare 1 time unit later.
  task automatic step(input bit r, input bit rx, input bit crc, input bit ack, input bit clr);
    @(negedge SP);
    reset = r; RX = rx; F_CRC_D = crc; F_ACK_D = ack; err_clr = clr;
    @(posedge SP);
    model_update(r, rx, crc, ack, clr);
    #1;
    for (int i = 0; i < NCFG; i++)
      check($sformatf("model_cfg%0d", i), 32'(dut_word(i)), 32'(model_word(i)));
  endtask

  typedef struct {
    bit rst, rx, crc, ack, clr;
    bit fe; bit [1:0] field; bit [3:0] pos; bit act, done, ovl; bit [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, rx, crc, ack, clr, input bit e_fe, input bit [1:0] e_fld,
                     input bit [3:0] e_pos, input bit e_act, e_done, e_ovl, input bit [7:0] e_cnt);
    vec_t v;
    v = '{rst, rx, crc, ack, clr, e_fe, e_fld, e_pos, e_act, e_done, e_ovl, e_cnt};
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; RX = 1'b1; F_CRC_D = 1'b0; F_ACK_D = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      m_err[i] = 0; m_in_eof[i] = 0; m_done[i] = 0; m_ovl[i] = 0;
      m_field[i] = 0; m_seen[i] = 0; m_cnt[i] = 0;
    end

    // Expected outputs of the EOF_LEN=7, receiver-mode instance (cfg0).
    //   rst rx crc ack clr | fe fld pos act done ovl cnt
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, 0, 0, 0, 4'(k), 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0,   0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 2, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 1, 0,   0, 0, 0, 1, 0, 0, 2);
    for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, 0, 0, 0, 4'(k), 1, 0, 0, 2);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 2);
    add(0, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 1, 1,   0, 0, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0, 1,   0, 0, 1, 1, 0, 0, 3);
    for (int k = 2; k <= 4; k++) add(0, 1, 0, 0, 0, 0, 0, 4'(k), 1, 0, 0, 3);
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].rx, vecs[n].crc, vecs[n].ack, vecs[n].clr);
      check($sformatf("vec%0d", n), 32'(dut_word(0)),
            32'({vecs[n].fe, vecs[n].field, vecs[n].pos, vecs[n].act,
                 vecs[n].done, vecs[n].ovl, vecs[n].cnt}));
    end

    // Two-bit counter saturates: 1,2,3,3,3 across five error/clear cycles.
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("sat_cnt%0d", k), 32'(cnt[2]), (k < 3) ? k + 1 : 3);
      step(0, 1, 0, 0, 1);
    end

    // Dominant last EOF bit: overload in receiver mode, EOF form error in transmitter mode.
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("last_eof_rx_ovl",  32'({ovl[0], fe[0]}), 32'b10);
    check("last_eof_tx_err",  32'({fe[1], fld[1], ovl[1]}), 32'b1110);
    step(0, 1, 0, 0, 0);
    check("ovl_one_cycle", 32'(ovl[0]), 32'd0);

    // Randomized traffic, checked every bit against the model for all four configurations.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(99) == 0, $urandom_range(99) < 85, $urandom_range(99) < 6,
           $urandom_range(99) < 12, $urandom_range(99) < 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
